stream_mux: RTL and testbench

Parametrised, registered N-bit, CH-channel stream multiplexer with valid/ready handshakes on every port. It selects one input channel per cycle by arbitration or by a forced select and captures its word into a single output register. It sits between the cipher's data sources (plaintext, key stream, test patterns) and the XOR datapath. It generalises the team's 2:1 combinational `mux` with channel count, flow control and fairness.

---
 rtl/stream_mux.sv | 88 ++++++++
 tb/tb_stream_mux.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/stream_mux.sv
// Registered CH-channel stream multiplexer with valid/ready on every port.
// Define STREAM_MUX_RR_EN for round-robin arbitration; otherwise fixed priority (lowest index).
module stream_mux #(
    parameter int  N  = 8,
    parameter int  CH = 4,
    localparam int CW = $clog2(CH)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [CH*N-1:0] in_data,
    input  logic [CH-1:0]   in_valid,
    output logic [CH-1:0]   in_ready,
    input  logic            sel_en,
    input  logic [CW-1:0]   sel,
    output logic [N-1:0]    out_data,
    output logic [CW-1:0]   out_ch,
    output logic            out_valid,
    input  logic            out_ready
);

    logic [CH-1:0][N-1:0] data_a;
    logic [CH-1:0]        elig;
    logic [CW-1:0]        g;
    logic                 any;
    logic                 load;

    assign data_a = in_data;

    // Out-of-range sel matches no lane, so forced mode then has an empty eligible set.
    for (genvar i = 0; i < CH; i++) begin : g_lane
        assign elig[i]     = in_valid[i] & (!sel_en | (sel == CW'(i)));
        assign in_ready[i] = load & (g == CW'(i)) & !rst;
    end

    assign any  = |elig;
    assign load = (!out_valid | out_ready) & any;

`ifdef STREAM_MUX_RR_EN
    logic [CW-1:0] ptr;
    logic [CW:0]   idx;
    logic          found;

    always_comb begin
        g     = '0;
        found = 1'b0;
        idx   = '0;
        for (int k = 0; k < CH; k++) begin
            idx = {1'b0, ptr} + (CW+1)'(k);
            if (idx >= (CW+1)'(CH))
                idx = idx - (CW+1)'(CH);
            if (!found && elig[idx[CW-1:0]]) begin
                g     = idx[CW-1:0];
                found = 1'b1;
            end
        end
    end

    // Pointer advances in forced mode too, so arbitration resumes after the forced channel.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            ptr <= '0;
        else if (load)
            ptr <= (g == CW'(CH-1)) ? '0 : g + 1'b1;
    end
`else
    always_comb begin
        g = '0;
        for (int i = CH-1; i >= 0; i--)
            if (elig[i])
                g = CW'(i);
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ch    <= '0;
        end else if (load) begin
            out_valid <= 1'b1;
            out_data  <= data_a[g];
            out_ch    <= g;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_stream_mux.sv
// Self-checking bench for stream_mux: directed cases plus randomized traffic against a behavioural model.
module tb_stream_mux;
    localparam int N  = 8;
    localparam int CH = 4;
    localparam int CW = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic [CH*N-1:0] in_data;
    logic [CH-1:0] in_valid;
    logic [CH-1:0] in_ready;
    logic          sel_en;
    logic [CW-1:0] sel;
    logic [N-1:0]  out_data;
    logic [CW-1:0] out_ch;
    logic          out_valid;
    logic          out_ready;

    // Three-channel instance: sel=3 is out of range there.
    logic [3*N-1:0] in_data3;
    logic [2:0]     in_valid3;
    logic [2:0]     in_ready3;
    logic           sel_en3;
    logic [1:0]     sel3;
    logic [N-1:0]   out_data3;
    logic [1:0]     out_ch3;
    logic           out_valid3;
    logic           out_ready3;

    always #5 clk = ~clk;

    stream_mux #(.N(N), .CH(CH)) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .sel_en(sel_en), .sel(sel), .out_data(out_data), .out_ch(out_ch),
        .out_valid(out_valid), .out_ready(out_ready)
    );

    stream_mux #(.N(N), .CH(3)) dut3 (
        .clk(clk), .rst(rst), .in_data(in_data3), .in_valid(in_valid3), .in_ready(in_ready3),
        .sel_en(sel_en3), .sel(sel3), .out_data(out_data3), .out_ch(out_ch3),
        .out_valid(out_valid3), .out_ready(out_ready3)
    );

    int total  = 0;
    int passed = 0;

    bit         m_valid;
    logic [7:0] m_data;
    int         m_ch;
    int         m_ptr;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask

    // Grant from the spec's rules: eligible set, then scan from ptr (RR) or from 0 (fixed).
    function automatic int pick(input logic [3:0] v, input logic se, input int s, input int p,
                                output bit any);
        logic [3:0] e;
        e   = se ? ((s < CH && v[s]) ? (4'b1 << s) : 4'b0) : v;
        any = (e != 4'b0);
`ifdef STREAM_MUX_RR_EN
        for (int k = 0; k < CH; k++)
            if (e[(p + k) % CH]) return (p + k) % CH;
`else
        for (int i = 0; i < CH; i++)
            if (e[i]) return i;
`endif
        return 0;
    endfunction

    task automatic model_reset();
        m_valid = 0;
        m_data  = 8'h00;
        m_ch    = 0;
        m_ptr   = 0;
    endtask

    // Called right after the inputs are set at a negedge; returns 1 time unit after the posedge.
    task automatic cycle();
        bit         any;
        int         g;
        bit         ld;
        logic [3:0] exp_rdy;
        #1;
        g       = pick(in_valid, sel_en, int'(sel), m_ptr, any);
        ld      = (!m_valid || out_ready) && any;
        exp_rdy = ld ? 4'(1 << g) : 4'b0;
        chk("in_ready", in_ready, exp_rdy);
        chk("in_ready3", in_ready3, 0);
        @(posedge clk);
        if (ld) begin
            m_data  = in_data[g*N +: N];
            m_ch    = g;
            m_valid = 1;
            m_ptr   = (g + 1) % CH;
        end else if (out_ready) begin
            m_valid = 0;
        end
        #1;
        chk("out_valid", out_valid, m_valid);
        if (m_valid) begin
            chk("out_data", out_data, m_data);
            chk("out_ch", out_ch, m_ch);
        end
        chk("out_valid3", out_valid3, 0);
    endtask

    initial begin
        int exp_ch [5];
        int exp_dat[5];
`ifdef STREAM_MUX_RR_EN
        exp_ch  = '{0, 1, 2, 3, 0};
        exp_dat = '{'h10, 'h21, 'h32, 'h43, 'h10};
`else
        exp_ch  = '{0, 0, 0, 0, 0};
        exp_dat = '{'h10, 'h10, 'h10, 'h10, 'h10};
`endif
        rst = 1'b1;
        in_data = '0; in_valid = '0; sel_en = 1'b0; sel = '0; out_ready = 1'b0;
        in_data3 = '0; in_valid3 = '0; sel_en3 = 1'b1; sel3 = 2'd3; out_ready3 = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        chk("rst_valid", out_valid, 0);
        chk("rst_data", out_data, 0);
        chk("rst_ch", out_ch, 0);
        chk("rst_ready", in_ready, 0);
        rst = 1'b0;

        // Hold a word under backpressure, then reset mid-operation.
        in_valid = 4'b0100; in_data = 32'h00A5_0000; out_ready = 1'b0;
        cycle();
        @(negedge clk);
        in_valid = 4'hF;
        #2 rst = 1'b1;
        #1;
        chk("midrst_valid", out_valid, 0);
        chk("midrst_data", out_data, 0);
        chk("midrst_ch", out_ch, 0);
        chk("midrst_ready", in_ready, 0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;

        // All channels valid, downstream always ready.
        in_data = 32'h4332_2110; in_valid = 4'hF; out_ready = 1'b1; sel_en = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            cycle();
            chk("seq_ch", out_ch, exp_ch[k]);
            chk("seq_data", out_data, exp_dat[k]);
        end

        // Backpressure: word from ch2 stays put for three stalled cycles.
        @(negedge clk);
        in_valid = 4'b0100; in_data = 32'h00A5_0000; out_ready = 1'b1;
        cycle();
        chk("bp_load_data", out_data, 8'hA5);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            in_valid = 4'hF; out_ready = 1'b0;
            #1 chk("bp_ready", in_ready, 0);
            cycle();
            chk("bp_data", out_data, 8'hA5);
            chk("bp_ch", out_ch, 2);
        end
        @(negedge clk);
        in_valid = 4'b0010; in_data = 32'h0000_5A00; out_ready = 1'b1;
        #1 chk("bp_release_ready", in_ready, 4'b0010);
        cycle();
        chk("bp_release_data", out_data, 8'h5A);

        // Forced select of ch3, then ch3 goes idle and the output drains.
        @(negedge clk);
        sel_en = 1'b1; sel = 2'd3; in_valid = 4'hF; in_data = 32'h4332_2110;
        #1 chk("forced_ready", in_ready, 4'b1000);
        cycle();
        chk("forced_ch", out_ch, 3);
        @(negedge clk);
        in_valid = 4'b0111;
        cycle();
        chk("forced_drain", out_valid, 0);

        // Randomized traffic.
        for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            in_data    = $urandom;
            in_valid   = 4'($urandom);
            sel_en     = ($urandom_range(0, 3) == 0);
            sel        = 2'($urandom);
            out_ready  = ($urandom_range(0, 9) < 7);
            in_data3   = 24'($urandom);
            in_valid3  = 3'($urandom);
            out_ready3 = 1'($urandom);
            cycle();
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
